aes_core_arbiter: RTL
=====================

Name: aes_core_arbiter

Overview:
- Shares one AES-128 encryption core between the TX and RX CCMP requesters. One block operation is in flight at a time.
- Arbitrates round-robin, registers and holds the winner's key and data, and drives the core's start/load strobes.
- Collects the core's result and returns it to the owning requester.
- Forwards per-direction abort/error to the core and recovers from a hung core with a watchdog.

Parameters:
- TIMEOUT_CYCLES, 32: maximum cycles in WAIT before the operation is abandoned. Must be ≥ 12.
- CNT_W, 6: width of the watchdog counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- pClk in 1: baseband clock.
- nSRst in 1: synchronous active-low reset.
- txReq in 1: TX requests an operation; held until txAck_p.
- txKey in 128: TX key.
- txData in 128: TX data block.
- txLoadFlag in 1: TX short-run flag passed to the core.
- tcTxErrorP in 1: TX error pulse.
- rxReq in 1: RX requests an operation; held until rxAck_p.
- rxKey in 128: RX key.
- rxData in 128: RX data block.
- rxLoadFlag in 1: RX short-run flag passed to the core.
- rxError_p in 1: RX error pulse.
- aesOutValid_p in 1: core result strobe.
- aesOutData in 128: core result.
- aesInValid out 1: core start strobe.
- aesKey out 128: key to the core, held stable for the whole operation.
- aesInData out 128: data to the core.
- loadFlag out 1: load flag to the core.
- aesRxError_p out 1: error pulse to the core's rxError_p.
- aesTxError_p out 1: error pulse to the core's tcTxErrorP.
- txAck_p out 1: TX request accepted.
- rxAck_p out 1: RX request accepted.
- txDone_p out 1: TX result valid on resultData.
- rxDone_p out 1: RX result valid on resultData.
- resultData out 128: registered result.
- busy out 1: high whenever state ≠ IDLE.
- timeoutErr_p out 1: watchdog fired.

Behaviour:
- Reset (nSRst=0 at a pClk edge):
  - state=IDLE; all outputs 0; aesKey/aesInData/resultData=0; lastGrant=RX (so TX wins the first tie).
  - Reset mid-operation abandons it: no done, no error pulse.
  - The core is reset by the same nSRst.
- States: IDLE, ISSUE, WAIT, DONE. owner is a 1-bit register (0=TX, 1=RX).
- IDLE:
  - Only one request high: grant it.
  - Both high: grant the one not equal to lastGrant.
  - On grant: capture that requester's key, data and loadFlag into the aesKey/aesInData/loadFlag registers; set owner and lastGrant; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - aesInValid=1.
  - Owner's ack_p=1.
  - Clear the watchdog.
  - Go to WAIT.
  - Requester latency: the request is sampled at edge T, and ack appears in the cycle after T.
- WAIT:
  - aesInValid=0. The watchdog increments each cycle.
  - aesOutValid_p=1: resultData<=aesOutData; go to DONE.
  - Owner's error input=1: pulse the matching core error output (TX→aesTxError_p, RX→aesRxError_p) for 1 cycle the next cycle; go to IDLE; no done.
  - Error and aesOutValid_p in the same cycle: error wins and the result is discarded.
  - Watchdog reaches TIMEOUT_CYCLES: pulse timeoutErr_p and both core error outputs for 1 cycle; go to IDLE.
- DONE (1 cycle):
  - Owner's done_p=1 with resultData valid; go to IDLE.
  - resultData holds its value until the next aesOutValid_p capture.
- Owner error in ISSUE: handled as in WAIT, but aesInValid is still issued in that cycle.
- Errors from the non-owner are ignored (not forwarded) while busy.
- Error inputs in IDLE are forwarded as a 1-cycle pulse to the matching core error output, so the core is cleaned up.
- A request raised while busy waits. Back-to-back: IDLE is re-entered after DONE, so the minimum spacing between aesInValid pulses is the core latency + 3 cycles.
- Outputs are registered except aesInValid, the ack_p signals, the done_p signals and busy, which decode directly from state.
- aesKey/aesInData/loadFlag change only on a grant.
- Requester inputs are don't-care except in the grant cycle.

Test Plan:
- Single TX:
  - Stimulus: txKey=000102030405060708090a0b0c0d0e0f, txData=00112233445566778899aabbccddeeff.
  - Required: txAck_p 1 cycle after the request; aesInValid a single pulse.
  - Required: txDone_p with resultData=69c4e0d86a7b0430d8cdb78070b4c55a; rxDone_p stays 0.
- Simultaneous txReq/rxReq from reset, both held:
  - Required grant order TX, RX, TX, RX.
  - Required: each done_p goes only to its owner; aesKey matches the owner throughout each operation.
- RX op with rxError_p asserted 3 cycles after rxAck_p:
  - Required: aesRxError_p pulses once; no rxDone_p; busy falls; a pending txReq is granted next.
- Core stubbed to never assert aesOutValid_p, TIMEOUT_CYCLES=32:
  - Required: timeoutErr_p, aesRxError_p and aesTxError_p each pulse once, 32 cycles after ISSUE; state returns to IDLE.
- During a TX op, inject rxError_p:
  - Required: no core error pulse; TX completes normally.
- rxError_p and aesOutValid_p in the same cycle:
  - Required: no rxDone_p; aesRxError_p pulses.
- nSRst low mid-WAIT:
  - Required: all outputs 0 at the next edge; no done pulse.
  - Required: a new txReq after release completes correctly.

Source files
------------

// File: rtl/aes_core_arbiter.sv
// Arbiter sharing one AES-128 core between TX and RX CCMP requesters.
// Ports: pClk/nSRst; tx*/rx* requester side; aes* core side; acks, dones, resultData, busy, timeoutErr_p.
module aes_core_arbiter #(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_W          = 6
) (
  input  logic         pClk,
  input  logic         nSRst,
  input  logic         txReq,
  input  logic [127:0] txKey,
  input  logic [127:0] txData,
  input  logic         txLoadFlag,
  input  logic         tcTxErrorP,
  input  logic         rxReq,
  input  logic [127:0] rxKey,
  input  logic [127:0] rxData,
  input  logic         rxLoadFlag,
  input  logic         rxError_p,
  input  logic         aesOutValid_p,
  input  logic [127:0] aesOutData,
  output logic         aesInValid,
  output logic [127:0] aesKey,
  output logic [127:0] aesInData,
  output logic         loadFlag,
  output logic         aesRxError_p,
  output logic         aesTxError_p,
  output logic         txAck_p,
  output logic         rxAck_p,
  output logic         txDone_p,
  output logic         rxDone_p,
  output logic [127:0] resultData,
  output logic         busy,
  output logic         timeoutErr_p
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_ONE = CNT_W'(1);

  state_t       state_q, state_d;
  logic         owner_q, owner_d;
  logic         last_grant_q, last_grant_d;
  logic [127:0] key_q, key_d;
  logic [127:0] data_q, data_d;
  logic         load_q, load_d;
  logic [127:0] result_q, result_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic         tx_err_q, tx_err_d;
  logic         rx_err_q, rx_err_d;
  logic         tmo_q, tmo_d;
  logic         grant_rx;
  logic         own_err;

  // owner: 0 = TX, 1 = RX
  assign own_err = owner_q ? rxError_p : tcTxErrorP;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    key_d        = key_q;
    data_d       = data_q;
    load_d       = load_q;
    result_d     = result_q;
    wd_d         = wd_q;
    tx_err_d     = 1'b0;
    rx_err_d     = 1'b0;
    tmo_d        = 1'b0;
    // RX wins only when alone, or on a tie after a TX grant
    grant_rx     = rxReq & (~txReq | ~last_grant_q);

    unique case (state_q)
      S_IDLE: begin
        // idle errors still reach the core so it can clean up
        tx_err_d = tcTxErrorP;
        rx_err_d = rxError_p;
        if (txReq | rxReq) begin
          owner_d      = grant_rx;
          last_grant_d = grant_rx;
          key_d        = grant_rx ? rxKey : txKey;
          data_d       = grant_rx ? rxData : txData;
          load_d       = grant_rx ? rxLoadFlag : txLoadFlag;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d = '0;
        if (own_err) begin
          tx_err_d = ~owner_q;
          rx_err_d = owner_q;
          state_d  = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        wd_d = wd_q + WD_ONE;
        // an owner error discards a result arriving in the same cycle
        if (own_err) begin
          tx_err_d = ~owner_q;
          rx_err_d = owner_q;
          state_d  = S_IDLE;
        end else if (aesOutValid_p) begin
          result_d = aesOutData;
          state_d  = S_DONE;
        end else if (wd_q == WD_LAST) begin
          tx_err_d = 1'b1;
          rx_err_d = 1'b1;
          tmo_d    = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pClk) begin
    if (!nSRst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      key_q        <= '0;
      data_q       <= '0;
      load_q       <= 1'b0;
      result_q     <= '0;
      wd_q         <= '0;
      tx_err_q     <= 1'b0;
      rx_err_q     <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      key_q        <= key_d;
      data_q       <= data_d;
      load_q       <= load_d;
      result_q     <= result_d;
      wd_q         <= wd_d;
      tx_err_q     <= tx_err_d;
      rx_err_q     <= rx_err_d;
      tmo_q        <= tmo_d;
    end
  end

  assign aesInValid   = (state_q == S_ISSUE);
  assign txAck_p      = (state_q == S_ISSUE) & ~owner_q;
  assign rxAck_p      = (state_q == S_ISSUE) & owner_q;
  assign txDone_p     = (state_q == S_DONE) & ~owner_q;
  assign rxDone_p     = (state_q == S_DONE) & owner_q;
  assign busy         = (state_q != S_IDLE);
  assign aesKey       = key_q;
  assign aesInData    = data_q;
  assign loadFlag     = load_q;
  assign resultData   = result_q;
  assign aesTxError_p = tx_err_q;
  assign aesRxError_p = rx_err_q;
  assign timeoutErr_p = tmo_q;

endmodule
